// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared states, sync byte and baud divisor helper for the ROM boot loader
package rom_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with input synchroniser, glitch-rejecting start check and stop-bit framing check
module uart_rx_byte
  import rom_loader_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] MID = CW'(DIV / 2 - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_t;
  rx_t st, st_n;
  logic [2:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic rx, fall, bit_tick, stop_tick;
  // sync[1] is the synchronised line, sync[2] its previous value for edge detection
  assign rx = sync[1];
  assign fall = sync[2] & ~sync[1];
  assign bit_tick = st == RX_BITS && cnt == LAST;
  assign stop_tick = st == RX_STOP && cnt == LAST;
  always_comb begin
    st_n = st;
    case (st)
      RX_IDLE:  st_n = fall ? RX_START : RX_IDLE;
      RX_START: st_n = cnt != MID ? RX_START : rx ? RX_IDLE : RX_BITS;
      RX_BITS:  st_n = bit_tick && idx == 3'd7 ? RX_STOP : RX_BITS;
      default:  st_n = stop_tick ? RX_IDLE : RX_STOP;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= RX_IDLE;
      sync <= 3'b111;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      byte_valid <= 1'b0;
      byte_data <= '0;
      frame_err <= 1'b0;
    end else begin
      st <= st_n;
      sync <= {sync[1:0], uart_rx};
      cnt <= (st_n != st || cnt == LAST) ? '0 : cnt + 1'b1;
      if (st == RX_START) idx <= '0;
      else if (bit_tick) begin
        sh <= {rx, sh[7:1]};
        idx <= idx + 1'b1;
      end
      byte_valid <= stop_tick & rx;
      frame_err <= stop_tick & ~rx;
      if (stop_tick & rx) byte_data <= sh;
    end
  end
endmodule

// File: rtl/rom_loader.sv
// rom_loader: UART boot loader that writes a framed, checksummed image into the instruction ROM
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 12,
  parameter int MAX_WORDS   = 4096,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [15:0] MAXW = 16'(MAX_WORDS);
  state_t st, st_n;
  logic byte_valid, frame_err, active, tmo_hit, take;
  logic [7:0] byte_data, sum;
  logic [15:0] len, widx, n_new;
  logic [1:0] bidx;
  logic [23:0] word;
  logic [TW-1:0] tmo;
  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk(clk),
    .rst(rst),
    .uart_rx(uart_rx),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .frame_err(frame_err)
  );
  assign active = st inside {LEN0, LEN1, DATA, CSUM};
  assign tmo_hit = active && tmo == TMO_LAST;
  assign take = byte_valid && !tmo_hit && !frame_err;
  assign n_new = {byte_data, len[7:0]};
  // DATA leaves for CSUM only in the cycle the last write is on the port, so rom_we stays inside DATA
  always_comb begin
    st_n = st;
    if (tmo_hit || (active && frame_err)) st_n = ERR;
    else if (st == DATA) st_n = (rom_we && widx == len) ? CSUM : DATA;
    else if (byte_valid)
      case (st)
        LEN0:    st_n = LEN1;
        LEN1:    st_n = n_new > MAXW ? ERR : n_new == 16'd0 ? CSUM : DATA;
        CSUM:    st_n = byte_data == sum ? DONE : ERR;
        default: st_n = byte_data == SYNC_BYTE ? LEN0 : st;
      endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      len <= '0;
      widx <= '0;
      bidx <= '0;
      sum <= '0;
      word <= '0;
      tmo <= '0;
      rom_we <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
      cpu_hold <= 1'b1;
      load_done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      st <= st_n;
      cpu_hold <= st_n != DONE;
      load_done <= st_n == DONE;
      load_err <= st_n == ERR;
      tmo <= (!active || byte_valid) ? '0 : tmo + 1'b1;
      rom_we <= 1'b0;
      if (take && st == LEN0) len[7:0] <= byte_data;
      if (take && st == LEN1) begin
        len[15:8] <= byte_data;
        widx <= '0;
        bidx <= '0;
        sum <= '0;
      end
      if (take && st == DATA) begin
        word <= {byte_data, word[23:8]};
        sum <= sum + byte_data;
        bidx <= bidx + 1'b1;
        if (bidx == 2'd3) begin
          rom_we <= 1'b1;
          rom_waddr <= widx[ADDR_W-1:0];
          rom_wdata <= {byte_data, word};
          widx <= widx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: random and directed frames checked against a frame-level reference parser
module tb_rom_loader;
  localparam int CLK_FREQ = 50000000, BAUD = 5000000, ADDR_W = 12, MAX_WORDS = 4096;
  localparam int TIMEOUT_CYC = 2000, BIT = 10;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
  logic rom_we, cpu_hold, load_done, load_err;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0] rom_wdata;
  int n_chk = 0, n_fail = 0;
  logic [ADDR_W-1:0] got_a[$], exp_a[$];
  logic [31:0] got_d[$], exp_d[$];
  always #5 clk = ~clk;
  rom_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS),
               .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rom_we(rom_we), .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata), .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );
  always @(negedge clk)
    if (rom_we) begin
      got_a.push_back(rom_waddr);
      got_d.push_back(rom_wdata);
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1, input int gap = 2);
    @(negedge clk) uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask
  task automatic send_all(input bq_t bs);
    foreach (bs[i]) send_byte(bs[i], 1'b1, $urandom_range(2, 30));
  endtask
  // frame-level reference: find sync, read N, slice words, compare checksum
  task automatic model(input bq_t bs, output logic done, output logic err);
    int i = 0, n;
    logic [7:0] s = 8'h00;
    exp_a.delete();
    exp_d.delete();
    done = 1'b0;
    err = 1'b0;
    while (i < bs.size() && bs[i] != 8'hA5) i++;
    i++;
    n = bs[i] + 256 * bs[i+1];
    i += 2;
    if (n > MAX_WORDS) begin
      err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      exp_a.push_back(ADDR_W'(k));
      exp_d.push_back({bs[i+3], bs[i+2], bs[i+1], bs[i]});
      s = 8'((s + bs[i] + bs[i+1] + bs[i+2] + bs[i+3]) % 256);
      i += 4;
    end
    err = bs[i] != s;
    done = !err;
  endtask
  task automatic run_frame(input string tag, input bq_t bs);
    logic d, e;
    model(bs, d, e);
    got_a.delete();
    got_d.delete();
    send_all(bs);
    repeat (5) @(negedge clk);
    check({tag, " nwrites"}, got_a.size(), exp_a.size());
    for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
      check({tag, " waddr"}, 32'(got_a[k]), 32'(exp_a[k]));
      check({tag, " wdata"}, got_d[k], exp_d[k]);
    end
    check({tag, " load_done"}, load_done, d);
    check({tag, " load_err"}, load_err, e);
    check({tag, " cpu_hold"}, cpu_hold, !d);
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bq_t f;
    repeat (5) @(negedge clk);
    check("rst rom_we", rom_we, 0);
    check("rst waddr", 32'(rom_waddr), 0);
    check("rst wdata", rom_wdata, 0);
    check("rst cpu_hold", cpu_hold, 1);
    check("rst load_done", load_done, 0);
    check("rst load_err", load_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    run_frame("two_words", f);
    f = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    run_frame("junk_lead", f);
    f = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    run_frame("bad_csum", f);
    f = '{8'hA5, 8'h01, 8'h10};
    run_frame("too_long", f);
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("empty", f);
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(0, 4);
      logic [7:0] s = 8'h00, b;
      f.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        f.push_back(b == 8'hA5 ? 8'h5A : b);
      end
      f.push_back(8'hA5);
      f.push_back(8'(n));
      f.push_back(8'(n >> 8));
      repeat (4 * n) begin
        b = 8'($urandom_range(0, 255));
        s = s + b;
        f.push_back(b);
      end
      f.push_back($urandom_range(0, 3) == 0 ? s ^ 8'(1 << $urandom_range(0, 7)) : s);
      run_frame("random", f);
    end
    got_a.delete();
    f = '{8'hA5, 8'h01, 8'h00, 8'h01};
    send_all(f);
    repeat (1500) @(negedge clk);
    check("timeout early err", load_err, 0);
    repeat (600) @(negedge clk);
    check("timeout err", load_err, 1);
    check("timeout hold", cpu_hold, 1);
    check("timeout nwrites", got_a.size(), 0);
    send_all(f);
    check("framing pre err", load_err, 0);
    send_byte(8'h02, 1'b0, 5);
    check("framing err", load_err, 1);
    check("framing done", load_done, 0);
    got_a.delete();
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
    send_all(f);
    repeat (3) @(negedge clk);
    check("pre_rst wdata", rom_wdata, 32'h00000013);
    #2 rst = 1'b1;
    #1;
    check("async rst rom_we", rom_we, 0);
    check("async rst wdata", rom_wdata, 0);
    check("async rst waddr", 32'(rom_waddr), 0);
    check("async rst hold", cpu_hold, 1);
    check("async rst done", load_done, 0);
    check("async rst err", load_err, 0);
    @(negedge clk) rst = 1'b0;
    f = '{8'h00, 8'h10, 8'h00, 8'hB6};
    send_all(f);
    repeat (5) @(negedge clk);
    check("post_rst nwrites", got_a.size(), 1);
    check("post_rst done", load_done, 0);
    check("post_rst hold", cpu_hold, 1);
    f = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
    run_frame("post_rst frame", f);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
